// File: rtl/phy_train_pkg.sv
// Shared types and helpers for the PHY deskew training controller and its lane trackers.
package phy_train_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET,
        ST_SETTLE,
        ST_SAMPLE,
        ST_UPDATE,
        ST_APPLY,
        ST_DONE
    } train_state_e;

    // Lengths need one more bit than codes so a full-sweep window (2**CODE_W) fits.
    function automatic int len_width(input int code_w);
        return code_w + 1;
    endfunction

    function automatic int count_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Fallback code for lanes without a usable eye.
    function automatic int unsigned mid_code(input int code_w);
        return 32'd1 << (code_w - 1);
    endfunction

endpackage

// File: rtl/phy_deskew_lane_tracker.sv
// Per-lane pattern check, longest-passing-window tracking and final centre selection.
module phy_deskew_lane_tracker
    import phy_train_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CODE_W  = 6,
    parameter int MIN_EYE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              set_i,
    input  logic              sample_en_i,
    input  logic              update_i,
    input  logic              last_code_i,
    input  logic              apply_i,
    input  logic [CODE_W-1:0] code_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic [DATA_W-1:0] pattern_a_i,
    input  logic [DATA_W-1:0] pattern_b_i,
    output logic [CODE_W-1:0] dl_ctrl_o,
    output logic              lane_pass_o,
    output logic [CODE_W:0]   eye_len_o
);
    localparam int LEN_W = len_width(CODE_W);

    logic              ok_q, ok_d;
    logic [CODE_W-1:0] run_start_q, run_start_d, best_start_q, best_start_d;
    logic [LEN_W-1:0]  run_len_q, run_len_d, best_len_q, best_len_d;
    logic [CODE_W-1:0] dl_q, dl_d;
    logic              pass_q, pass_d;
    logic [LEN_W-1:0]  eye_q, eye_d;

    logic              match;
    logic [CODE_W-1:0] run_start_new;
    logic [LEN_W-1:0]  run_len_new;
    logic [LEN_W-1:0]  centre;

    always_comb begin
        ok_d         = ok_q;
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        dl_d         = dl_q;
        pass_d       = pass_q;
        eye_d        = eye_q;

        match         = (word_i == pattern_a_i) || (word_i == pattern_b_i);
        run_start_new = run_start_q;
        run_len_new   = run_len_q;
        if (ok_q) begin
            if (run_len_q == '0) run_start_new = code_i;
            run_len_new = run_len_q + LEN_W'(1);
        end
        centre = LEN_W'(best_start_q) + ((best_len_q - LEN_W'(1)) >> 1);

        if (clr_i) begin
            ok_d         = 1'b1;
            run_start_d  = '0;
            run_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
            pass_d       = 1'b0;
            eye_d        = '0;
        end else begin
            if (set_i) dl_d = code_i;
            if (sample_en_i) ok_d = ok_q & match;
            // ok is re-armed here so it is already 1 when the next code's sampling begins.
            if (update_i) begin
                ok_d        = 1'b1;
                run_start_d = run_start_new;
                run_len_d   = run_len_new;
                if (!ok_q || last_code_i) begin
                    if (run_len_new > best_len_q) begin
                        best_start_d = run_start_new;
                        best_len_d   = run_len_new;
                    end
                    run_len_d = '0;
                end
            end
            if (apply_i) begin
                if (best_len_q >= LEN_W'(MIN_EYE)) begin
                    dl_d   = centre[CODE_W-1:0];
                    pass_d = 1'b1;
                end else begin
                    dl_d   = CODE_W'(mid_code(CODE_W));
                    pass_d = 1'b0;
                end
                eye_d = best_len_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ok_q         <= 1'b0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            dl_q         <= '0;
            pass_q       <= 1'b0;
            eye_q        <= '0;
        end else begin
            ok_q         <= ok_d;
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            dl_q         <= dl_d;
            pass_q       <= pass_d;
            eye_q        <= eye_d;
        end
    end

    assign dl_ctrl_o   = dl_q;
    assign lane_pass_o = pass_q;
    assign eye_len_o   = eye_q;

endmodule

// File: rtl/phy_deskew_trainer.sv
// Multi-lane DCDL deskew trainer: sweeps all codes, then centres each lane in its widest eye.
module phy_deskew_trainer
    import phy_train_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int DATA_W  = 8,
    parameter int CODE_W  = 6,
    parameter int SETTLE  = 16,
    parameter int SAMPLES = 8,
    parameter int MIN_EYE = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [DATA_W-1:0]          pattern_a,
    input  logic [DATA_W-1:0]          pattern_b,
    input  logic                       rx_valid,
    input  logic [LANES*DATA_W-1:0]    rx_dout,
    output logic [LANES*CODE_W-1:0]    dl_ctrl,
    output logic                       busy,
    output logic                       done,
    output logic [LANES-1:0]           lane_pass,
    output logic [LANES*(CODE_W+1)-1:0] eye_len
);
    localparam int SET_W = count_width(SETTLE);
    localparam int SMP_W = count_width(SAMPLES);

    train_state_e      state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [SMP_W-1:0]  smp_q, smp_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic clr_s, set_s, sample_s, update_s, apply_s, last_code_s;

    assign last_code_s = (code_q == {CODE_W{1'b1}});

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        settle_d = settle_q;
        smp_d    = smp_q;
        busy_d   = busy_q;
        done_d   = done_q;
        clr_s    = 1'b0;
        set_s    = 1'b0;
        sample_s = 1'b0;
        update_s = 1'b0;
        apply_s  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SET;
                    code_d  = '0;
                    clr_s   = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            ST_SET: begin
                set_s    = 1'b1;
                settle_d = SET_W'(SETTLE - 1);
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    smp_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (rx_valid) begin
                    sample_s = 1'b1;
                    if (smp_q == SMP_W'(SAMPLES - 1)) state_d = ST_UPDATE;
                    else                              smp_d   = smp_q + SMP_W'(1);
                end
            end
            ST_UPDATE: begin
                update_s = 1'b1;
                if (last_code_s) begin
                    state_d = ST_APPLY;
                end else begin
                    code_d  = code_q + CODE_W'(1);
                    state_d = ST_SET;
                end
            end
            ST_APPLY: begin
                apply_s = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            code_q   <= '0;
            settle_q <= '0;
            smp_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            settle_q <= settle_d;
            smp_q    <= smp_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        phy_deskew_lane_tracker #(
            .DATA_W (DATA_W),
            .CODE_W (CODE_W),
            .MIN_EYE(MIN_EYE)
        ) u_trk (
            .clk        (clk),
            .reset      (reset),
            .clr_i      (clr_s),
            .set_i      (set_s),
            .sample_en_i(sample_s),
            .update_i   (update_s),
            .last_code_i(last_code_s),
            .apply_i    (apply_s),
            .code_i     (code_q),
            .word_i     (rx_dout[l*DATA_W +: DATA_W]),
            .pattern_a_i(pattern_a),
            .pattern_b_i(pattern_b),
            .dl_ctrl_o  (dl_ctrl[l*CODE_W +: CODE_W]),
            .lane_pass_o(lane_pass[l]),
            .eye_len_o  (eye_len[l*(CODE_W+1) +: CODE_W+1])
        );
    end

endmodule

// File: tb/tb_phy_deskew_trainer.sv
// Directed bench: a per-lane code-window model feeds RX words; results and latency are checked.
module tb_phy_deskew_trainer;
    localparam int LANES = 4, DATA_W = 8, CODE_W = 4;

    logic                       clk = 1'b0;
    logic                       reset, start, rx_valid;
    logic [DATA_W-1:0]          pattern_a = 8'h55, pattern_b = 8'hAA;
    logic [LANES*DATA_W-1:0]    rx_dout;
    logic [LANES*CODE_W-1:0]    dl_ctrl;
    logic                       busy, done;
    logic [LANES-1:0]           lane_pass;
    logic [LANES*(CODE_W+1)-1:0] eye_len;

    phy_deskew_trainer #(
        .LANES(LANES), .DATA_W(DATA_W), .CODE_W(CODE_W),
        .SETTLE(4), .SAMPLES(4), .MIN_EYE(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .pattern_a(pattern_a), .pattern_b(pattern_b),
        .rx_valid(rx_valid), .rx_dout(rx_dout),
        .dl_ctrl(dl_ctrl), .busy(busy), .done(done),
        .lane_pass(lane_pass), .eye_len(eye_len)
    );

    always #5 clk = ~clk;

    int          nchk = 0, nerr = 0;
    logic [15:0] mask [LANES];
    bit          tog = 0, err_en = 0;
    int          err_code = 0, err_since = 0;
    int          since = 0;
    logic [3:0]  prev_dl = '0, dc;
    logic [7:0]  w;

    // Lane model: `since` counts edges since lane 0's code changed, which locates settle/sample slots.
    always @(negedge clk) begin
        if (dl_ctrl[3:0] != prev_dl) since = 0;
        else                         since = since + 1;
        prev_dl  = dl_ctrl[3:0];
        rx_valid = tog ? (since % 2 == 1) : 1'b1;
        for (int l = 0; l < LANES; l++) begin
            dc = dl_ctrl[l*CODE_W +: CODE_W];
            if (mask[l][dc]) w = (since % 2 == 1) ? pattern_a : pattern_b;
            else             w = pattern_a ^ 8'h01;
            if (err_en && l == 0 && int'(dc) == err_code && since == err_since) w = pattern_a ^ 8'h10;
            rx_dout[l*DATA_W +: DATA_W] = w;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_train(input string tag, input bit mid_start, input bit rst_mid, input int exp_lat);
        int cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_on"}, busy, 1);
        chk({tag, "_done_clr"}, done, 0);
        while (done !== 1'b1 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) chk({tag, "_dl_code0"}, dl_ctrl, 0);
            start = mid_start && (cnt == 7);
            if (rst_mid && cnt == 57) begin
                chk({tag, "_dl_code5"}, dl_ctrl, 16'h5555);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk({tag, "_rst_busy"}, busy, 0);
                chk({tag, "_rst_dl"}, dl_ctrl, 0);
                chk({tag, "_rst_done"}, done, 0);
                chk({tag, "_rst_eye"}, eye_len, 0);
                return;
            end
        end
        start = 1'b0;
        chk({tag, "_latency"}, cnt, exp_lat);
        chk({tag, "_busy_off"}, busy, 0);
    endtask

    task automatic chk_res(input string tag, input logic [15:0] edl, input logic [19:0] eeye, input logic [3:0] epass);
        chk({tag, "_dl"}, dl_ctrl, edl);
        chk({tag, "_eye"}, eye_len, eeye);
        chk({tag, "_pass"}, lane_pass, epass);
    endtask

    localparam logic [19:0] EYE_A = {5'd4, 5'd3, 5'd5, 5'd7};

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mask[0] = 16'h03F8;   // 3..9
        mask[1] = 16'h1F0E;   // 1..3 and 8..12
        mask[2] = 16'h1C1C;   // 2..4 and 10..12
        mask[3] = 16'hF000;   // 12..15
        repeat (3) @(negedge clk);
        chk("rst_dl", dl_ctrl, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", lane_pass, 0);
        chk("rst_eye", eye_len, 0);
        reset = 1'b0;
        @(negedge clk);

        run_train("A", 0, 0, 161);
        chk_res("A", 16'hD3A6, EYE_A, 4'hF);
        chk("A_done", done, 1);

        tog = 1;
        run_train("B_toggle", 1, 0, 225);
        chk_res("B_toggle", 16'hD3A6, EYE_A, 4'hF);
        tog = 0;

        mask[0] = 16'h0000;
        run_train("C_nopass", 0, 0, 161);
        chk_res("C_nopass", 16'hD3A8, {5'd4, 5'd3, 5'd5, 5'd0}, 4'hE);

        mask[0] = 16'h0020;
        err_en = 1; err_code = 5; err_since = 6;
        run_train("D_err", 0, 0, 161);
        chk_res("D_err", 16'hD3A8, {5'd4, 5'd3, 5'd5, 5'd0}, 4'hE);

        mask[0] = 16'h00E0;
        run_train("E_err", 0, 0, 161);
        chk_res("E_err", 16'hD3A6, {5'd4, 5'd3, 5'd5, 5'd2}, 4'hF);
        err_en = 0;

        mask[0] = 16'h03F8;
        run_train("F_rst", 0, 1, 0);
        @(negedge clk);
        run_train("G_retrain", 0, 0, 161);
        chk_res("G_retrain", 16'hD3A6, EYE_A, 4'hF);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
